alu_share_arbiter: RTL and testbench

//  Shares the single datapath ALU between two requesters: r0 = main core, r1 = debug/coprocessor port.

---
 rtl/alu_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one datapath ALU between the main core (r0) and the debug port (r1).
// Define ALU_ARB_STATS_EN to build the saturating per-requester grant counters.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_req_valid,
  output logic             r0_req_ready,
  input  logic [3:0]       r0_op,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic [WIDTH-1:0] r0_rsp_data,
  output logic             r0_rsp_err,
  input  logic             r1_req_valid,
  output logic             r1_req_ready,
  input  logic [3:0]       r1_op,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [WIDTH-1:0] r1_rsp_data,
  output logic             r1_rsp_err,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1,
  output logic [1:0]       state_dbg
);

  // Handshake: a request transfers on a cycle where req_valid & req_ready are both high,
  // a response on a cycle where rsp_valid & rsp_ready are both high; valid never waits on ready.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, RESP = 2'd3} state_t;

  state_t           state, state_nxt;
  logic             last_gnt, gnt, op_err;
  logic [3:0]       op_q, op_in;
  logic [WIDTH-1:0] a_q, b_q, data_q, a_in, b_in;
  logic             win0, win1, accept, rsp_ready_sel, drive_alu;

  function automatic logic op_supported(input logic [3:0] op);
    case (op)
      4'b0001, 4'b0010, 4'b1010, 4'b1011, 4'b1100,
      4'b1101, 4'b0111, 4'b0011, 4'b0100, 4'b0110: op_supported = 1'b1;
      default:                                     op_supported = 1'b0;
    endcase
  endfunction

  // On a tie the requester that did not win last time is served.
  always_comb begin
    win0          = r0_req_valid & (~r1_req_valid | last_gnt);
    win1          = r1_req_valid & (~r0_req_valid | ~last_gnt);
    r0_req_ready  = (state == IDLE) & win0;
    r1_req_ready  = (state == IDLE) & win1;
    accept        = r0_req_ready | r1_req_ready;
    op_in         = win1 ? r1_op : r0_op;
    a_in          = win1 ? r1_a  : r0_a;
    b_in          = win1 ? r1_b  : r0_b;
    rsp_ready_sel = gnt ? r1_rsp_ready : r0_rsp_ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    if (rsp_ready_sel) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The ALU is combinational on alu_*, so its result is sampled as ISSUE closes,
  // while the operands are still applied; CAPTURE then presents it in RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt <= 1'b1;
      gnt      <= 1'b0;
      op_err   <= 1'b0;
      op_q     <= 4'b0000;
      a_q      <= '0;
      b_q      <= '0;
      data_q   <= '0;
    end else begin
      if (accept) begin
        gnt      <= win1;
        last_gnt <= win1;
        op_q     <= op_in;
        a_q      <= a_in;
        b_q      <= b_in;
        op_err   <= ~op_supported(op_in);
      end
      if (state == ISSUE) data_q <= op_err ? '0 : alu_result;
    end
  end

  assign drive_alu    = (state == ISSUE) & ~op_err;
  assign alu_ctrl     = drive_alu ? op_q : 4'b0000;
  assign alu_a        = drive_alu ? a_q  : '0;
  assign alu_b        = drive_alu ? b_q  : '0;
  assign busy         = (state != IDLE);
  assign state_dbg    = state;

  assign r0_rsp_valid = (state == RESP) & ~gnt;
  assign r1_rsp_valid = (state == RESP) &  gnt;
  assign r0_rsp_data  = r0_rsp_valid ? data_q : '0;
  assign r1_rsp_data  = r1_rsp_valid ? data_q : '0;
  assign r0_rsp_err   = r0_rsp_valid & op_err;
  assign r1_rsp_err   = r1_rsp_valid & op_err;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (r0_req_ready & r0_req_valid & ~(&cnt0_q)) cnt0_q <= cnt0_q + 1'b1;
      if (r1_req_ready & r1_req_valid & ~(&cnt1_q)) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`else
  assign gnt_cnt0 = '0;
  assign gnt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_alu_share_arbiter;
  localparam int W = 32;
`ifdef ALU_ARB_STATS_EN
  localparam int CW    = 2;
  localparam bit STATS = 1'b1;
`else
  localparam int CW    = 16;
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          r0_req_valid, r0_req_ready, r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
  logic          r1_req_valid, r1_req_ready, r1_rsp_valid, r1_rsp_ready, r1_rsp_err;
  logic [3:0]    r0_op, r1_op, alu_ctrl;
  logic [W-1:0]  r0_a, r0_b, r1_a, r1_b, r0_rsp_data, r1_rsp_data;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic          busy;
  logic [CW-1:0] gnt_cnt0, gnt_cnt1;
  logic [1:0]    state_dbg;

  alu_share_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_rsp_data(r0_rsp_data), .r0_rsp_err(r0_rsp_err),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_rsp_data(r1_rsp_data), .r1_rsp_err(r1_rsp_err),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .busy(busy), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- ALU environment and reference rules ----------------
  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    sa = a;
    case (op)
      4'h1:    return a + b;
      4'h2:    return a - b;
      4'hA:    return a & b;
      4'hB:    return a | b;
      4'hC:    return a ^ b;
      4'hD:    return ~(a | b);
      4'h7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h3:    return a << b[4:0];
      4'h4:    return a >> b[4:0];
      4'h6:    return sa >>> b[4:0];
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic bit op_ok(input logic [3:0] op);
    logic [3:0] ok_list [10] = '{4'h1, 4'h2, 4'hA, 4'hB, 4'hC, 4'hD, 4'h7, 4'h3, 4'h4, 4'h6};
    for (int i = 0; i < 10; i++) if (ok_list[i] === op) return 1'b1;
    return 1'b0;
  endfunction

  always_comb alu_result = alu_fn(alu_ctrl, alu_a, alu_b);

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: ph counts cycles since accept (0 = free); one response in flight at most.
  int           ph = 0;
  logic         m_last = 1'b1, m_gnt = 1'b0;
  logic [3:0]   m_op;
  logic [W-1:0] m_a, m_b;
  int           m_cnt0 = 0, m_cnt1 = 0;
  logic [W:0]   exp_q[$];
  logic         e_rdy0, e_rdy1, e_v0, e_v1;
  logic [3:0]   e_ctrl;
  logic [W-1:0] e_a, e_b;
  int           cmax;

  initial cmax = (1 << CW) - 1;

  always @(negedge clk) begin
    if (reset) begin
      check("rst_alu_ctrl", alu_ctrl, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_busy", busy, 0);
      check("rst_r0_rsp_valid", r0_rsp_valid, 0);
      check("rst_r1_rsp_valid", r1_rsp_valid, 0);
      check("rst_r0_rsp_data", r0_rsp_data, 0);
      check("rst_r1_rsp_data", r1_rsp_data, 0);
      check("rst_r0_rsp_err", r0_rsp_err, 0);
      check("rst_r1_rsp_err", r1_rsp_err, 0);
      check("rst_gnt_cnt0", gnt_cnt0, 0);
      check("rst_gnt_cnt1", gnt_cnt1, 0);
      ph = 0; m_last = 1'b1; m_gnt = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
      exp_q.delete();
    end else begin
      e_rdy0 = (ph == 0) && r0_req_valid && (!r1_req_valid || m_last);
      e_rdy1 = (ph == 0) && r1_req_valid && (!r0_req_valid || !m_last);
      check("r0_req_ready", r0_req_ready, e_rdy0);
      check("r1_req_ready", r1_req_ready, e_rdy1);
      check("busy", busy, ph != 0);
      e_ctrl = 4'h0; e_a = '0; e_b = '0;
      if (ph == 1 && op_ok(m_op)) begin e_ctrl = m_op; e_a = m_a; e_b = m_b; end
      check("alu_ctrl", alu_ctrl, e_ctrl);
      check("alu_a", alu_a, e_a);
      check("alu_b", alu_b, e_b);
      e_v0 = (ph == 3) && !m_gnt;
      e_v1 = (ph == 3) && m_gnt;
      check("r0_rsp_valid", r0_rsp_valid, e_v0);
      check("r1_rsp_valid", r1_rsp_valid, e_v1);
      if (ph == 3 && exp_q.size() != 0) begin
        check(m_gnt ? "r1_rsp_data" : "r0_rsp_data", m_gnt ? r1_rsp_data : r0_rsp_data, exp_q[0][W-1:0]);
        check(m_gnt ? "r1_rsp_err" : "r0_rsp_err", m_gnt ? r1_rsp_err : r0_rsp_err, exp_q[0][W]);
      end
      check("gnt_cnt0", gnt_cnt0, STATS ? m_cnt0 : 0);
      check("gnt_cnt1", gnt_cnt1, STATS ? m_cnt1 : 0);
      case (ph)
        0: if (e_rdy0 || e_rdy1) begin
             m_gnt  = e_rdy1;
             m_last = e_rdy1;
             m_op   = e_rdy1 ? r1_op : r0_op;
             m_a    = e_rdy1 ? r1_a  : r0_a;
             m_b    = e_rdy1 ? r1_b  : r0_b;
             exp_q.push_back({!op_ok(m_op), op_ok(m_op) ? alu_fn(m_op, m_a, m_b) : {W{1'b0}}});
             if (e_rdy1) begin if (m_cnt1 < cmax) m_cnt1++; end
             else        begin if (m_cnt0 < cmax) m_cnt0++; end
             ph = 1;
           end
        1: ph = 2;
        2: ph = 3;
        default: if (m_gnt ? r1_rsp_ready : r0_rsp_ready) begin
             void'(exp_q.pop_front());
             ph = 0;
           end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int n, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (n == 0) begin r0_req_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b; end
    else        begin r1_req_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b; end
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = (n == 0) ? (r0_req_valid && r0_req_ready) : (r1_req_valid && r1_req_ready);
    end
    check((n == 0) ? "accept_r0" : "accept_r1", got, 1);
    @(posedge clk); #1;
    if (n == 0) r0_req_valid = 1'b0;
    else        r1_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = !busy && !r0_req_valid && !r1_req_valid;
    end
    check("idle_wait", done, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk); #2 reset = 1'b0;
  endtask

  task automatic rand_req(input int n, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(n, 4'($urandom_range(0, 15)), $urandom, $urandom);
    end
  endtask

  // ---------------- stimulus ----------------
  bit stop = 1'b0;

  initial begin
    reset = 1'b1;
    r0_req_valid = 1'b0; r0_op = 4'h0; r0_a = '0; r0_b = '0; r0_rsp_ready = 1'b1;
    r1_req_valid = 1'b0; r1_op = 4'h0; r1_a = '0; r1_b = '0; r1_rsp_ready = 1'b1;
    #22 reset = 1'b0;

    // r0 alone: 5 + 7
    send(0, 4'h1, 32'd5, 32'd7);
    wait_idle();

    // tie from reset: r0 sub first, then r1 xor, then another tie goes to r0
    pulse_reset();
    fork
      send(0, 4'h2, 32'd9, 32'd4);
      send(1, 4'hC, 32'hF0, 32'h0F);
    join
    fork
      send(0, 4'hB, 32'h1234, 32'h8000);
      send(1, 4'h7, 32'hFFFF_FFFF, 32'd1);
    join
    wait_idle();

    // unsupported op on r1
    send(1, 4'hF, 32'd123, 32'd456);
    wait_idle();

    // r0 response stalled 5 cycles while r1 waits
    r0_rsp_ready = 1'b0;
    fork
      send(0, 4'h6, 32'h8000_0000, 32'd4);
      begin @(posedge clk); send(1, 4'hD, 32'h0F0F_0000, 32'h00F0_000F); end
      begin
        for (int i = 0; i < 50 && !r0_rsp_valid; i++) @(negedge clk);
        repeat (5) @(posedge clk);
        #1 r0_rsp_ready = 1'b1;
      end
    join
    wait_idle();

    // reset during CAPTURE discards the transaction
    send(0, 4'h1, 32'd5, 32'd7);
    @(negedge clk);
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk); #2 reset = 1'b0;
    repeat (4) @(negedge clk);
    send(0, 4'h1, 32'd5, 32'd7);
    wait_idle();

    // random traffic with random response back-pressure
    fork
      begin
        fork
          rand_req(0, 30);
          rand_req(1, 30);
        join
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk); #1;
          r0_rsp_ready = ($urandom_range(0, 3) != 0);
          r1_rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    r0_rsp_ready = 1'b1;
    r1_rsp_ready = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
